// File: rtl/elastic_pipe.sv
// rtl/elastic_pipe.sv - N-stage elastic register pipeline with valid/ready backpressure, flush and occupancy
// Each stage holds a data register and a valid bit. A stage may load whenever it is
// empty or the stage after it can move, so empty stages fill even while the output
// is stalled (bubbles collapse). Flush clears only the valid bits; data is don't-care
// once invalid.
module elastic_pipe #(
  parameter int               N           = 3,
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(N+1)-1:0]   occupancy
);

  localparam int OW = $clog2(N + 1);

  logic [N-1:0]     valid_q;
  logic [WIDTH-1:0] data_q [N];
  logic [N-1:0]     rdy;
  logic [OW-1:0]    occ_q;
  logic             accept;
  logic             emit;

  // Readiness ripples from the output back toward the input; any empty stage
  // makes every stage upstream of it ready.
  always_comb begin
    rdy        = '0;
    rdy[N-1]   = !valid_q[N-1] | out_ready;
    for (int i = N - 2; i >= 0; i--) begin
      rdy[i] = !valid_q[i] | rdy[i+1];
    end
  end

  assign in_ready  = rdy[0] & !flush;
  assign out_valid = valid_q[N-1];
  assign out_data  = data_q[N-1];
  assign occupancy = occ_q;
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  // Stage registers: reset loads RESET_VALUE, flush drops all valids, otherwise
  // each ready stage takes its predecessor (stage 0 takes the input port).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < N; i++) begin
        data_q[i] <= RESET_VALUE;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      if (rdy[0]) begin
        valid_q[0] <= in_valid;
        data_q[0]  <= in_data;
      end
      for (int i = 1; i < N; i++) begin
        if (rdy[i]) begin
          valid_q[i] <= valid_q[i-1];
          data_q[i]  <= data_q[i-1];
        end
      end
    end
  end

  // Occupancy tracks accepts minus emits; accept is impossible when full and
  // stalled, and emit is impossible when empty, so the count never wraps.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      occ_q <= '0;
    end else begin
      case ({accept, emit})
        2'b10:   occ_q <= occ_q + OW'(1);
        2'b01:   occ_q <= occ_q - OW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // The count must always agree with the number of set valid bits.
  occ_matches_valids: assert property (@(posedge clk) disable iff (!reset_n)
    int'(occ_q) == $countones(valid_q));

endmodule

// File: tb/tb_elastic_pipe.sv
// tb/tb_elastic_pipe.sv - scoreboard bench for elastic_pipe (N=3 and N=1 instances)
module tb_elastic_pipe;

  logic       clk = 1'b0;
  logic       reset_n;

  logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_occupancy;

  logic       b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_in_data, b_out_data;
  logic [0:0] b_occupancy;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  elastic_pipe #(.N(3), .WIDTH(8), .RESET_VALUE(8'hA5)) dut_a (
    .clk(clk), .reset_n(reset_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occupancy)
  );

  elastic_pipe #(.N(1), .WIDTH(8), .RESET_VALUE(8'h3C)) dut_b (
    .clk(clk), .reset_n(reset_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occupancy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: at the negedge check readiness against the model and run the
  // scoreboard for whatever the coming edge transfers; after the edge check occupancy.
  task automatic cycle();
    logic [7:0] e;
    @(negedge clk);
    if (!reset_n) begin
      qa.delete();
      qb.delete();
    end else begin
      chk("a_in_ready", a_in_ready, (!a_flush && (qa.size() < 3 || a_out_ready)) ? 1 : 0);
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) chk("a_unexpected_emit", a_out_valid & a_out_ready, 0);
        else begin
          e = qa.pop_front();
          chk("a_out_data", a_out_data, e);
        end
      end
      if (a_in_valid && a_in_ready) qa.push_back(a_in_data);
      if (a_flush) qa.delete();

      chk("b_in_ready", b_in_ready, (!b_flush && (qb.size() < 1 || b_out_ready)) ? 1 : 0);
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) chk("b_unexpected_emit", b_out_valid & b_out_ready, 0);
        else begin
          e = qb.pop_front();
          chk("b_out_data", b_out_data, e);
        end
      end
      if (b_in_valid && b_in_ready) qb.push_back(b_in_data);
      if (b_flush) qb.delete();
    end
    @(posedge clk);
    #1;
    if (reset_n) begin
      chk("a_occupancy", a_occupancy, qa.size());
      chk("b_occupancy", b_occupancy, qb.size());
    end
  endtask

  initial begin
    reset_n = 1'b0;
    a_flush = 1'b0; a_in_valid = 1'b1; a_in_data = 8'hEE; a_out_ready = 1'b1;
    b_flush = 1'b0; b_in_valid = 1'b1; b_in_data = 8'hEE; b_out_ready = 1'b1;

    // Reset held two cycles with in_valid high
    cycle();
    cycle();
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_occupancy", a_occupancy, 0);
    chk("rst_a_out_data", a_out_data, 8'hA5);
    chk("rst_b_out_valid", b_out_valid, 0);
    chk("rst_b_out_data", b_out_data, 8'h3C);
    reset_n = 1'b1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    cycle();
    chk("post_rst_a_occupancy", a_occupancy, 0);

    // Latency: single item through an empty pipe
    a_in_valid = 1'b1; a_in_data = 8'h11;
    cycle();
    a_in_valid = 1'b0;
    chk("lat_edge0_out_valid", a_out_valid, 0);
    cycle();
    chk("lat_edge1_out_valid", a_out_valid, 0);
    cycle();
    chk("lat_edge2_out_valid", a_out_valid, 1);
    chk("lat_edge2_out_data", a_out_data, 8'h11);

    // Back-to-back stream 0x01..0x10
    for (int v = 1; v <= 16; v++) begin
      a_in_valid = 1'b1; a_in_data = 8'(v);
      cycle();
      if (v >= 3) chk("stream_occ_steady", a_occupancy, 3);
    end
    a_in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("drain_out_valid", a_out_valid, 1);
      cycle();
    end
    chk("drain_empty_out_valid", a_out_valid, 0);

    // Backpressure: fill with A,B,C while stalled
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'hA1; cycle();
    a_in_data = 8'hB2; cycle();
    a_in_data = 8'hC3; cycle();
    a_in_data = 8'hDD;
    chk("full_occupancy", a_occupancy, 3);
    chk("full_in_ready", a_in_ready, 0);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("stall_out_data", a_out_data, 8'hA1);
      chk("stall_out_valid", a_out_valid, 1);
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    #1;
    chk("release_in_ready", a_in_ready, 1);
    chk("release_first", a_out_data, 8'hA1);
    cycle();
    chk("release_second", a_out_data, 8'hB2);
    cycle();
    chk("release_third", a_out_data, 8'hC3);
    cycle();
    chk("release_empty", a_out_valid, 0);

    // Bubble collapse under a stalled output
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'h4A; cycle();
    a_in_valid = 1'b0; cycle(); cycle();
    chk("bubble_a_at_out", a_out_valid, 1);
    a_in_valid = 1'b1; a_in_data = 8'h4B; cycle();
    a_in_valid = 1'b0; cycle();
    chk("bubble_valid_q", dut_a.valid_q, 3'b110);
    chk("bubble_occupancy", a_occupancy, 2);
    chk("bubble_in_ready", a_in_ready, 1);
    chk("bubble_out_data", a_out_data, 8'h4A);
    cycle();
    chk("bubble_hold_valid_q", dut_a.valid_q, 3'b110);

    // Flush with two items in flight and a new item offered
    a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = 8'h55;
    #1;
    chk("flush_in_ready", a_in_ready, 0);
    cycle();
    a_flush = 1'b0; a_in_valid = 1'b0;
    chk("flush_occupancy", a_occupancy, 0);
    chk("flush_out_valid", a_out_valid, 0);
    a_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    chk("flush_nothing_emitted", a_out_valid, 0);

    // Single-stage pipe with out_ready toggling 1,0,1
    b_in_valid = 1'b1;
    for (int k = 0; k < 15; k++) begin
      b_out_ready = ((k % 3) != 1);
      b_in_data = 8'(8'h60 + k);
      cycle();
      chk("b_occ_range", (b_occupancy <= 1) ? 1 : 0, 1);
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    cycle();
    cycle();
    chk("b_drained_occupancy", b_occupancy, 0);
    chk("b_drained_out_valid", b_out_valid, 0);
    chk("b_model_empty", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
